// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the Memory stage.
// Holds the instruction codes, the status codes, the "no register" id and the
// encoding of the data-memory access FSM.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'ha;
  localparam logic [3:0] I_POPQ   = 4'hb;

  // Status codes, one-hot
  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  // Register id meaning "no destination"
  localparam logic [3:0] RNONE = 4'hf;

  // Data-memory access FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_decode.sv
// mem_access_decode: classifies an instruction for the data-memory port.
// Optional feature: define DMEM_ALIGN_CHECK_EN to also fault addresses that
// are not 8-byte aligned.
// Ports:
//   icode, stat      : instruction code and pipeline status
//   val_e, val_a     : ALU result and register operand (address candidates)
//   rd, wr           : instruction reads / writes data memory
//   addr             : byte address of the access
//   addr_fault       : AOK access op whose address must not reach memory
module mem_access_decode
  import y86_pkg::*;
#(
  parameter int              DW         = 64,
  parameter logic [DW-1:0]   ADDR_LIMIT = 64'h2000
) (
  input  logic [3:0]    icode,
  input  logic [3:0]    stat,
  input  logic [DW-1:0] val_e,
  input  logic [DW-1:0] val_a,
  output logic          rd,
  output logic          wr,
  output logic [DW-1:0] addr,
  output logic          addr_fault
);

  logic range_fault;
  logic align_fault;

  always_comb begin
    rd   = 1'b0;
    wr   = 1'b0;
    addr = val_e;
    case (icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: wr = 1'b1;
      I_MRMOVQ:                  rd = 1'b1;
      // Stack pops address through the old %rsp carried in valA
      I_POPQ, I_RET: begin
        rd   = 1'b1;
        addr = val_a;
      end
      default: ;
    endcase
  end

  assign range_fault = (addr >= ADDR_LIMIT);

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_fault = (addr[2:0] != 3'b000);
`else
  assign align_fault = 1'b0;
`endif

  // A non-AOK instruction already carries its own status; only AOK accesses
  // get upgraded to ADR here.
  assign addr_fault = (rd | wr) && (stat == STAT_AOK) && (range_fault || align_fault);

endmodule

// File: rtl/memory_stage_pipe.sv
// memory_stage_pipe: Y86-64 Memory stage with the M pipeline register and a
// req/ack data-memory handshake.
// Optional feature: DMEM_ALIGN_CHECK_EN (misaligned accesses fault as ADR).
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   e_*                     : Execute-stage results loaded into M
//   M_bubble                : load a bubble into M (stall wins over bubble)
//   dmem_req/we/addr/wdata  : access request, held stable until dmem_ack
//   dmem_ack/rdata/err      : completion, read data and fault, valid with ack
//   m_busy                  : freezes F/D/E while an access is outstanding
//   m_*                     : M register contents, resolved status, load value
module memory_stage_pipe
  import y86_pkg::*;
#(
  parameter logic [63:0] ADDR_LIMIT = 64'h2000,
  parameter int          DW         = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    e_stat,
  input  logic [3:0]    e_icode,
  input  logic          e_Cnd,
  input  logic [DW-1:0] e_valE,
  input  logic [DW-1:0] e_valA,
  input  logic [3:0]    e_dstE,
  input  logic [3:0]    e_dstM,
  input  logic          M_bubble,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_err,
  output logic          m_busy,
  output logic [3:0]    m_stat,
  output logic [3:0]    m_icode,
  output logic          m_Cnd,
  output logic [DW-1:0] m_valA,
  output logic [DW-1:0] m_valE,
  output logic [DW-1:0] m_valM,
  output logic [3:0]    m_dstE,
  output logic [3:0]    m_dstM
);

  // M pipeline register
  logic [3:0]    stat_reg,  stat_next;
  logic [3:0]    icode_reg, icode_next;
  logic          cnd_reg,   cnd_next;
  logic [DW-1:0] vale_reg,  vale_next;
  logic [DW-1:0] vala_reg,  vala_next;
  logic [3:0]    dste_reg,  dste_next;
  logic [3:0]    dstm_reg,  dstm_next;

  // Access FSM and its results
  mem_state_t    state_reg, state_next;
  logic [DW-1:0] valm_reg,  valm_next;
  logic          err_reg,   err_next;

  // Value M would take if it loads this cycle
  logic [3:0]    in_stat, in_icode;
  logic [DW-1:0] in_vale, in_vala;
  logic          in_rd, in_wr, in_fault, in_need_mem;
  logic [DW-1:0] in_addr;

  // Decode of the held M contents
  logic          m_rd, m_wr, m_fault;
  logic [DW-1:0] m_addr;

  always_comb begin
    if (M_bubble) begin
      in_stat  = STAT_AOK;
      in_icode = I_NOP;
      in_vale  = '0;
      in_vala  = '0;
    end else begin
      in_stat  = e_stat;
      in_icode = e_icode;
      in_vale  = e_valE;
      in_vala  = e_valA;
    end
  end

  mem_access_decode #(.DW(DW), .ADDR_LIMIT(ADDR_LIMIT[DW-1:0])) u_dec_in (
    .icode      (in_icode),
    .stat       (in_stat),
    .val_e      (in_vale),
    .val_a      (in_vala),
    .rd         (in_rd),
    .wr         (in_wr),
    .addr       (in_addr),
    .addr_fault (in_fault)
  );

  mem_access_decode #(.DW(DW), .ADDR_LIMIT(ADDR_LIMIT[DW-1:0])) u_dec_m (
    .icode      (icode_reg),
    .stat       (stat_reg),
    .val_e      (vale_reg),
    .val_a      (vala_reg),
    .rd         (m_rd),
    .wr         (m_wr),
    .addr       (m_addr),
    .addr_fault (m_fault)
  );

  // in_addr only feeds the fault check inside the decoder
  assign in_need_mem = (in_rd | in_wr) && (in_stat == STAT_AOK) && !in_fault
                       && (in_addr == in_addr);

  // Next-state logic: M loads in every state except ACCESS
  always_comb begin
    state_next = state_reg;
    valm_next  = valm_reg;
    err_next   = err_reg;
    stat_next  = stat_reg;
    icode_next = icode_reg;
    cnd_next   = cnd_reg;
    vale_next  = vale_reg;
    vala_next  = vala_reg;
    dste_next  = dste_reg;
    dstm_next  = dstm_reg;
    case (state_reg)
      ST_ACCESS: begin
        if (dmem_ack) begin
          valm_next  = m_rd ? dmem_rdata : '0;
          err_next   = dmem_err;
          state_next = ST_DONE;
        end
      end
      default: begin
        stat_next  = in_stat;
        icode_next = in_icode;
        vale_next  = in_vale;
        vala_next  = in_vala;
        cnd_next   = M_bubble ? 1'b0  : e_Cnd;
        dste_next  = M_bubble ? RNONE : e_dstE;
        dstm_next  = M_bubble ? RNONE : e_dstM;
        valm_next  = '0;
        err_next   = 1'b0;
        state_next = in_need_mem ? ST_ACCESS : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      valm_reg  <= '0;
      err_reg   <= 1'b0;
      stat_reg  <= STAT_AOK;
      icode_reg <= I_NOP;
      cnd_reg   <= 1'b0;
      vale_reg  <= '0;
      vala_reg  <= '0;
      dste_reg  <= RNONE;
      dstm_reg  <= RNONE;
    end else begin
      state_reg <= state_next;
      valm_reg  <= valm_next;
      err_reg   <= err_next;
      stat_reg  <= stat_next;
      icode_reg <= icode_next;
      cnd_reg   <= cnd_next;
      vale_reg  <= vale_next;
      vala_reg  <= vala_next;
      dste_reg  <= dste_next;
      dstm_reg  <= dstm_next;
    end
  end

  // Request attributes come straight from the held M register, so they cannot
  // move while the stage is stalled in ACCESS.
  assign dmem_req   = (state_reg == ST_ACCESS);
  assign dmem_we    = m_wr;
  assign dmem_addr  = m_addr;
  assign dmem_wdata = vala_reg;
  assign m_busy     = (state_reg == ST_ACCESS);

  assign m_stat  = (err_reg || m_fault) ? STAT_ADR : stat_reg;
  assign m_icode = icode_reg;
  assign m_Cnd   = cnd_reg;
  assign m_valA  = vala_reg;
  assign m_valE  = vale_reg;
  assign m_valM  = valm_reg;
  assign m_dstE  = dste_reg;
  assign m_dstM  = dstm_reg;

endmodule
